// File: rtl/core_bus_arbiter_pkg.sv
// Shared types for the core bus arbiter and related bus masters.
package core_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_D = 1'b0,
    OWN_I = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/core_bus_arbiter_timeout.sv
// Bus ack-timeout counter: counts held-request cycles and flags the last allowed one.
module bus_timeout_counter #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(LIMIT);

  logic [CW-1:0] count;

  assign expired = (count == CW'(LIMIT - 1));

  // Count enabled cycles; saturate at the final cycle so expiry stays asserted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/core_bus_arbiter.sv
// Round-robin arbiter sharing one Wishbone master port between the data (D)
// and instruction (I) requesters, one outstanding transaction at a time.
module core_bus_arbiter
  import core_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W           = 32,
  parameter int unsigned DATA_W           = 32,
  parameter int unsigned TIMEOUT_CYCLES   = 1024,
  parameter int unsigned D_PRIORITY_RESET = 1
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [DATA_W/8-1:0] d_sel_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic                d_done_o,
  output logic                d_err_o,
  input  logic                i_req_i,
  input  logic [ADDR_W-1:0]   i_addr_i,
  output logic [DATA_W-1:0]   i_rdata_o,
  output logic                i_done_o,
  output logic                i_err_o,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic                wb_we_o,
  output logic [DATA_W/8-1:0] wb_sel_o,
  output logic [ADDR_W-1:0]   wb_addr_o,
  output logic [DATA_W-1:0]   wb_data_o,
  input  logic [DATA_W-1:0]   wb_data_i,
  input  logic                wb_ack_i,
  output logic                busy_o
);

  localparam int unsigned SEL_W = DATA_W / 8;
  localparam logic [SEL_W-1:0] SEL_ALL = '1;
  localparam arb_owner_e LAST_GRANT_RST = (D_PRIORITY_RESET != 0) ? OWN_I : OWN_D;

  arb_state_e state, state_next;
  arb_owner_e owner, last_grant, grant_owner;
  logic       grant;
  logic       err_flag;
  logic       resp_hold;
  logic       expired;

  // The cycle carrying a done pulse is the requester's last cycle with req held,
  // so grants are suppressed there to avoid re-issuing the finished request.
  assign resp_hold = d_done_o | i_done_o;
  assign busy_o    = (state != IDLE);

  bus_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk_i),
    .rst     (reset_i),
    .clear   (grant),
    .enable  (state == BUS),
    .expired (expired)
  );

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and round-robin grant selection.
  always_comb begin
    state_next  = state;
    grant       = 1'b0;
    grant_owner = OWN_D;
    case (state)
      IDLE: begin
        if (!resp_hold) begin
          if (d_req_i && i_req_i) begin
            grant       = 1'b1;
            grant_owner = (last_grant == OWN_D) ? OWN_I : OWN_D;
          end else if (d_req_i) begin
            grant       = 1'b1;
            grant_owner = OWN_D;
          end else if (i_req_i) begin
            grant       = 1'b1;
            grant_owner = OWN_I;
          end
          if (grant) state_next = BUS;
        end
      end
      BUS:     if (wb_ack_i || expired) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bus output registers, read-data capture and completion pulses.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      owner      <= OWN_D;
      last_grant <= LAST_GRANT_RST;
      err_flag   <= 1'b0;
      wb_cyc_o   <= 1'b0;
      wb_stb_o   <= 1'b0;
      wb_we_o    <= 1'b0;
      wb_sel_o   <= '0;
      wb_addr_o  <= '0;
      wb_data_o  <= '0;
      d_rdata_o  <= '0;
      i_rdata_o  <= '0;
      d_done_o   <= 1'b0;
      d_err_o    <= 1'b0;
      i_done_o   <= 1'b0;
      i_err_o    <= 1'b0;
    end else begin
      d_done_o <= 1'b0;
      d_err_o  <= 1'b0;
      i_done_o <= 1'b0;
      i_err_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            owner    <= grant_owner;
            err_flag <= 1'b0;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            if (grant_owner == OWN_D) begin
              wb_we_o   <= d_we_i;
              wb_sel_o  <= d_sel_i;
              wb_addr_o <= d_addr_i;
              wb_data_o <= d_wdata_i;
            end else begin
              wb_we_o   <= 1'b0;
              wb_sel_o  <= SEL_ALL;
              wb_addr_o <= i_addr_i;
              wb_data_o <= '0;
            end
          end
        end
        BUS: begin
          if (wb_ack_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            if (!wb_we_o) begin
              if (owner == OWN_D) d_rdata_o <= wb_data_i;
              else                i_rdata_o <= wb_data_i;
            end
          end else if (expired) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            err_flag <= 1'b1;
          end
        end
        RESP: begin
          if (owner == OWN_D) begin
            d_done_o <= 1'b1;
            d_err_o  <= err_flag;
          end else begin
            i_done_o <= 1'b1;
            i_err_o  <= err_flag;
          end
          last_grant <= owner;
          err_flag   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/core_bus_arbiter.md
Name: core_bus_arbiter

Overview:
- Shares one Wishbone master port between the core's data requester (port D) and instruction requester (port I).
- Sits between the core wrapper and the Controller bus (core_cyc/stb/we/sel/addr/data).
- Used in builds with a single memory port, i.e. no second memory.
- Provides round-robin arbitration, one outstanding transaction, registered bus outputs and an ack timeout that returns a bus error to the requester.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; SEL_W = DATA_W/8.
- TIMEOUT_CYCLES, 1024, cycles of held cyc/stb without ack before abort; must be >= 2.
- D_PRIORITY_RESET, 1, the port treated as last-granted at reset is I, so D wins the first tie.

Ports:
- clk_i  in  1  core clock.
- reset_i  in  1  asynchronous, active-high reset.
- d_req_i  in  1  data request; held with d_* fields until d_done_o.
- d_we_i  in  1  1 = write.
- d_sel_i  in  SEL_W  byte enables.
- d_addr_i  in  ADDR_W  byte address.
- d_wdata_i  in  DATA_W  write data.
- d_rdata_o  out  DATA_W  read data, valid with d_done_o.
- d_done_o  out  1  one-cycle completion pulse.
- d_err_o  out  1  one-cycle error pulse (timeout); coincides with d_done_o.
- i_req_i  in  1  instruction fetch request (read only); held until i_done_o.
- i_addr_i  in  ADDR_W  fetch address.
- i_rdata_o  out  DATA_W  fetched word.
- i_done_o  out  1  completion pulse.
- i_err_o  out  1  access-fault pulse.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1  Wishbone control.
- wb_sel_o  out  SEL_W  Wishbone byte select.
- wb_addr_o  out  ADDR_W  Wishbone address.
- wb_data_o  out  DATA_W  Wishbone write data.
- wb_data_i  in  DATA_W  Wishbone read data.
- wb_ack_i  in  1  Wishbone acknowledge.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous): state=IDLE; all outputs 0; last_grant=I; timeout counter=0; rdata registers 0.
- FSM states:
  - IDLE: if no request, stay. If exactly one request, grant it. If both request, grant the port that is not last_grant. On grant: latch we/sel/addr/wdata into the bus output registers; set cyc=stb=1 on the next edge; record the owner; counter=0; go to BUS.
  - I-port grants drive we=0 and sel=all-ones.
  - BUS: cyc, stb and all fields held constant.
    - If wb_ack_i: latch wb_data_i into the owner's rdata; drop cyc/stb; go to RESP.
    - Else if counter==TIMEOUT_CYCLES-1: drop cyc/stb; set the error flag; go to RESP.
    - Else counter++.
  - RESP: pulse the owner's done_o (and err_o if flagged) for exactly one cycle; last_grant=owner; clear the flag; go to IDLE.
- Latency: req seen at edge N -> cyc/stb high after edge N+1 -> ack sampled at edge M -> done high for the cycle after edge M+1. Minimum 3 cycles from req to done for a zero-wait slave.
- The next grant is evaluated in IDLE, one idle cycle after RESP. Back-to-back throughput is therefore one transaction per 4 cycles at minimum.
- Requesters deassert req in the cycle after done. A req still high in IDLE is treated as a new request.
- rdata_o holds its value until the next completion on that port. Writes leave rdata unchanged.
- Requests arriving while busy wait; no queueing beyond the held req.
- A req that drops before done is protocol misuse. The transaction still completes and done still pulses.
- An ack arriving in the same cycle as timeout expiry counts as success; no error.
- wb_ack_i outside BUS is ignored.
- A pipelined (one-cycle-delayed) ack from the wrapper is tolerated: stb stays high until ack, so there is no double issue.
- Reset mid-transaction: cyc/stb drop immediately (asynchronous); no done pulse.

Decomposition:
- Shared package: state enum {IDLE, BUS, RESP}; owner encoding (OWN_D=0, OWN_I=1); SEL_ALL constant.
- Timeout counter as sub-module bus_timeout_counter (clear, enable, expired), reused by other bus masters.

Test Plan:
- Single D write, addr 0x100, wdata 0xDEADBEEF, sel 0xF, slave acks after 2 wait cycles -> cyc/stb/we high for exactly 3 cycles with fields stable; d_done_o one pulse; d_err_o=0.
- Single I read of 0x0, slave returns 0x00000013 with zero wait -> i_rdata_o=0x00000013, i_done_o exactly 3 cycles after req; wb_sel_o=0xF, wb_we_o=0.
- D and I requested in the same cycle after reset -> D served first, then I. Both held continuously -> grants alternate D, I, D, I over 4 transactions.
- Slave never acks, TIMEOUT_CYCLES=8 -> cyc held 8 cycles then drops; d_done_o and d_err_o pulse together; next request serviced normally.
- Ack arriving exactly on the final timeout cycle -> done=1, err=0, rdata captured.
- reset_i asserted while in BUS -> wb_cyc_o=0 asynchronously; no done pulse; after release, a new request completes normally.
